// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       OP;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemToRead;
    logic             MemToWrite;
    logic             MemToReg;
    logic             IRWrite;
    logic             RegWrite;
    logic             ALUSrcA;
    logic             BEQ_BNE;
    logic             NbitBranchSelect;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [2:0]       ALUOp;
    logic [3:0]       state_o;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  OP,
        output PCWrite, PCWriteCond, IorD, MemToRead, MemToWrite, MemToReg,
               IRWrite, RegWrite, ALUSrcA, BEQ_BNE, NbitBranchSelect,
               ALUSrcB, PCSource, ALUOp, state_o, halted, illegal, retired
    );

    modport slave (
        output OP,
        input  PCWrite, PCWriteCond, IorD, MemToRead, MemToWrite, MemToReg,
               IRWrite, RegWrite, ALUSrcA, BEQ_BNE, NbitBranchSelect,
               ALUSrcB, PCSource, ALUOp, state_o, halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: per-state datapath controls, HALT, illegal-opcode
// detection and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t           state, next_state;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    logic op_r, op_i, op_lw, op_sw, op_br, op_j, op_halt;

    assign op_r    = (bus.OP[5:4] == 2'b00);
    assign op_i    = (bus.OP[5:4] == 2'b01);
    assign op_lw   = (bus.OP == 6'b100000);
    assign op_sw   = (bus.OP == 6'b100001);
    assign op_br   = (bus.OP == 6'b100010) || (bus.OP == 6'b100011);
    assign op_j    = (bus.OP == 6'b100100);
    assign op_halt = (bus.OP == 6'b111111);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            retired_q <= '0;
        end else begin
            state <= next_state;
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.state_o          = state;
    assign bus.retired          = retired_q;
    assign bus.NbitBranchSelect = !rst && op_r;

    always_comb begin
        next_state      = state;
        retire          = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemToRead   = 1'b0;
        bus.MemToWrite  = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.BEQ_BNE     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 3'b000;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;

        case (state)
            FETCH: begin
                bus.MemToRead = 1'b1;
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = 2'b01;
                bus.PCWrite   = 1'b1;
                next_state    = DECODE;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b10;
                if (op_r)                next_state = EXEC_R;
                else if (op_i)           next_state = EXEC_I;
                else if (op_lw || op_sw) next_state = MEM_ADDR;
                else if (op_br)          next_state = BRANCH;
                else if (op_j)           next_state = JUMP;
                else if (op_halt) begin
                    next_state = HALT;
                    retire     = 1'b1;
                end else begin
                    next_state  = FETCH;
                    bus.illegal = 1'b1;
                end
            end
            EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = bus.OP[2:0];
                next_state  = ALU_WB;
            end
            EXEC_I: begin
                // OP[3] selects the zero-extended immediate on mux input 3
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = bus.OP[3] ? 2'b11 : 2'b10;
                bus.ALUOp   = bus.OP[2:0];
                next_state  = ALU_WB;
            end
            ALU_WB: begin
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                next_state   = FETCH;
            end
            MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                next_state  = op_sw ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.IorD      = 1'b1;
                bus.MemToRead = 1'b1;
                next_state    = MEM_WB;
            end
            MEM_WB: begin
                bus.MemToReg = 1'b1;
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                next_state   = FETCH;
            end
            MEM_WR: begin
                bus.IorD       = 1'b1;
                bus.MemToWrite = 1'b1;
                retire         = 1'b1;
                next_state     = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 3'b001;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BEQ_BNE     = bus.OP[0];
                retire          = 1'b1;
                next_state      = FETCH;
            end
            JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                retire       = 1'b1;
                next_state   = FETCH;
            end
            HALT: begin
                bus.halted = 1'b1;
                next_state = HALT;
            end
            default: next_state = FETCH;
        endcase

        // Reset overrides everything so an aborted instruction issues no writes
        if (rst) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.IorD        = 1'b0;
            bus.MemToRead   = 1'b0;
            bus.MemToWrite  = 1'b0;
            bus.MemToReg    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.ALUSrcA     = 1'b0;
            bus.BEQ_BNE     = 1'b0;
            bus.ALUSrcB     = 2'b00;
            bus.PCSource    = 2'b00;
            bus.ALUOp       = 3'b000;
            bus.halted      = 1'b0;
            bus.illegal     = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-state control vectors, retire count,
// illegal pulse, HALT hold and reset abort, all against hand-written constants.
module tb_multicycle_control;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_ret;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemToRead,MemToWrite,MemToReg,IRWrite,RegWrite,
    //  ALUSrcA,BEQ_BNE,ALUSrcB[1:0],PCSource[1:0],ALUOp[2:0]}
    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_000;
    localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_0_1_0_0_0_01_00_000;
    localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_10_00_000;
    localparam logic [16:0] C_EXR001 = 17'b0_0_0_0_0_0_0_0_1_0_00_00_001;
    localparam logic [16:0] C_EXI_Z  = 17'b0_0_0_0_0_0_0_0_1_0_11_00_010;
    localparam logic [16:0] C_EXI_S  = 17'b0_0_0_0_0_0_0_0_1_0_10_00_101;
    localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_1_0_0_00_00_000;
    localparam logic [16:0] C_MADDR  = 17'b0_0_0_0_0_0_0_0_1_0_10_00_000;
    localparam logic [16:0] C_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_000;
    localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_1_0_1_0_0_00_00_000;
    localparam logic [16:0] C_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_000;
    localparam logic [16:0] C_BNE    = 17'b0_1_0_0_0_0_0_0_1_1_00_01_001;
    localparam logic [16:0] C_BEQ    = 17'b0_1_0_0_0_0_0_0_1_0_00_01_001;
    localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_10_000;

    function automatic logic [16:0] ctl_now();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemToRead,
                bus.MemToWrite, bus.MemToReg, bus.IRWrite, bus.RegWrite,
                bus.ALUSrcA, bus.BEQ_BNE, bus.ALUSrcB, bus.PCSource, bus.ALUOp};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic [16:0] ctl);
        check({tag, " state"}, 32'(bus.state_o), 32'(st));
        check({tag, " ctl"}, 32'(ctl_now()), 32'(ctl));
        check({tag, " illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    // Starts in FETCH, walks n post-FETCH states, then expects FETCH again.
    task automatic instr(input string tag, input logic [5:0] op, input int n,
                         input logic [3:0] s1, input logic [16:0] c1,
                         input logic [3:0] s2, input logic [16:0] c2,
                         input logic [3:0] s3, input logic [16:0] c3,
                         input logic [3:0] s4, input logic [16:0] c4);
        logic [3:0]  st [4];
        logic [16:0] ct [4];
        st[0] = s1; st[1] = s2; st[2] = s3; st[3] = s4;
        ct[0] = c1; ct[1] = c2; ct[2] = c3; ct[3] = c4;
        bus.OP = op;
        #1;
        expect_st({tag, " fetch"}, 4'd0, C_FETCH);
        check({tag, " nbit"}, 32'(bus.NbitBranchSelect), 32'(op[5:4] == 2'b00));
        for (int k = 0; k < n; k++) begin
            step();
            expect_st($sformatf("%s s%0d", tag, k + 1), st[k], ct[k]);
        end
        step();
        check({tag, " end state"}, 32'(bus.state_o), 32'd0);
        check({tag, " retired"}, bus.retired, 32'(exp_ret));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_ret = 0;
        rst     = 1'b1;
        bus.OP  = 6'b000001;
        step();
        step();
        expect_st("reset", 4'd0, C_ZERO);
        check("reset retired", bus.retired, 32'd0);
        check("reset halted", 32'(bus.halted), 32'd0);
        check("reset nbit", 32'(bus.NbitBranchSelect), 32'd0);

        rst = 1'b0;
        exp_ret = 1;
        instr("R001", 6'b000001, 3, 4'd1, C_DECODE, 4'd2, C_EXR001, 4'd4, C_ALUWB, 4'd0, C_ZERO);
        exp_ret = 2;
        instr("LW", 6'b100000, 4, 4'd1, C_DECODE, 4'd5, C_MADDR, 4'd6, C_MRD, 4'd7, C_MWB);
        exp_ret = 3;
        instr("SW", 6'b100001, 3, 4'd1, C_DECODE, 4'd5, C_MADDR, 4'd8, C_MWR, 4'd0, C_ZERO);
        exp_ret = 4;
        instr("BNE", 6'b100011, 2, 4'd1, C_DECODE, 4'd9, C_BNE, 4'd0, C_ZERO, 4'd0, C_ZERO);
        exp_ret = 5;
        instr("BEQ", 6'b100010, 2, 4'd1, C_DECODE, 4'd9, C_BEQ, 4'd0, C_ZERO, 4'd0, C_ZERO);
        exp_ret = 6;
        instr("I010z", 6'b011010, 3, 4'd1, C_DECODE, 4'd3, C_EXI_Z, 4'd4, C_ALUWB, 4'd0, C_ZERO);
        exp_ret = 7;
        instr("I101s", 6'b010101, 3, 4'd1, C_DECODE, 4'd3, C_EXI_S, 4'd4, C_ALUWB, 4'd0, C_ZERO);
        exp_ret = 8;
        instr("J", 6'b100100, 2, 4'd1, C_DECODE, 4'd10, C_JUMP, 4'd0, C_ZERO, 4'd0, C_ZERO);

        bus.OP = 6'b101010;
        step();
        check("ill state", 32'(bus.state_o), 32'd1);
        check("ill pulse", 32'(bus.illegal), 32'd1);
        check("ill ctl", 32'(ctl_now()), 32'(C_DECODE));
        step();
        check("ill next state", 32'(bus.state_o), 32'd0);
        check("ill pulse end", 32'(bus.illegal), 32'd0);
        check("ill retired", bus.retired, 32'd8);

        bus.OP = 6'b111111;
        step();
        check("halt decode", 32'(bus.state_o), 32'd1);
        step();
        for (int i = 0; i < 20; i++) begin
            check("halt state", 32'(bus.state_o), 32'd11);
            check("halt flag", 32'(bus.halted), 32'd1);
            check("halt ctl", 32'(ctl_now()), 32'(C_ZERO));
            check("halt retired", bus.retired, 32'd9);
            step();
        end
        rst = 1'b1;
        #1;
        check("halt rst halted", 32'(bus.halted), 32'd0);
        step();
        check("halt rst state", 32'(bus.state_o), 32'd0);
        check("halt rst retired", bus.retired, 32'd0);
        rst = 1'b0;
        #1;
        check("post rst fetch", 32'(ctl_now()), 32'(C_FETCH));

        bus.OP = 6'b000001;
        step();
        step();
        step();
        check("abort pre ctl", 32'(ctl_now()), 32'(C_ALUWB));
        rst = 1'b1;
        #1;
        check("abort ctl", 32'(ctl_now()), 32'(C_ZERO));
        check("abort nbit", 32'(bus.NbitBranchSelect), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("abort state", 32'(bus.state_o), 32'd0);
        check("abort retired", bus.retired, 32'd0);
        exp_ret = 1;
        instr("R110", 6'b000110, 3, 4'd1, C_DECODE, 4'd2, 17'b0_0_0_0_0_0_0_0_1_0_00_00_110,
              4'd4, C_ALUWB, 4'd0, C_ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
